// File: rtl/sdr_wb_bist.sv
// Wishbone master BIST: writes an LFSR pattern in bursts, reads it back, checks it.
// Ports: wb_* master bus, cfg_* test setup, start/busy/done/pass/err_cnt/first_err_addr status.
module sdr_wb_bist #(
  parameter int          AW   = 26,
  parameter int          DW   = 32,
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          sdr_init_done,
  input  logic          start,
  input  logic [AW-1:0] cfg_start_addr,
  input  logic [15:0]   cfg_num_bursts,
  input  logic [7:0]    cfg_burst_len,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] first_err_addr
);

  localparam logic [31:0] SEED_EFF =
    (SEED == 32'h0) ? 32'h1 : SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WR,
    S_WR_GAP,
    S_RD_GAP,
    S_RD,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [31:0]   lfsr;
  logic [AW-1:0] addr;
  logic [AW-1:0] base;
  logic [7:0]    beat;
  logic [7:0]    len_m1;
  logic [15:0]   bcnt;
  logic [15:0]   nb_m1;

  logic accept;
  logic ack;
  logic last_beat;
  logic last_burst;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] l
  );
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Bus outputs are pure decodes of the state register.
  assign wb_cyc_o  = (state == S_WR) || (state == S_RD);
  assign wb_stb_o  = wb_cyc_o;
  assign wb_we_o   = (state == S_WR);
  assign wb_sel_o  = {4{wb_stb_o}};
  assign wb_addr_o = addr;
  assign wb_dat_o  = wb_we_o ? lfsr : '0;

  // busy stays high through the done cycle, so a start
  // arriving together with done is dropped.
  assign accept     = start && !busy && (state == S_IDLE);
  assign ack        = wb_ack_i && wb_stb_o;
  assign last_beat  = (beat == len_m1);
  assign last_burst = (bcnt == nb_m1);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_d = (cfg_num_bursts == 16'd0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (sdr_init_done) state_d = S_WR;
      end
      S_WR: begin
        if (ack && last_beat)
          state_d = last_burst ? S_RD_GAP : S_WR_GAP;
      end
      S_WR_GAP: state_d = S_WR;
      S_RD_GAP: state_d = S_RD;
      S_RD: begin
        if (ack && last_beat)
          state_d = last_burst ? S_DONE : S_RD_GAP;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lfsr           <= SEED_EFF;
      addr           <= '0;
      base           <= '0;
      beat           <= '0;
      len_m1         <= '0;
      bcnt           <= '0;
      nb_m1          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;

      if (accept) begin
        base           <= cfg_start_addr;
        addr           <= cfg_start_addr;
        len_m1         <= (cfg_burst_len == 8'd0) ?
                          8'd0 : cfg_burst_len - 8'd1;
        nb_m1          <= cfg_num_bursts - 16'd1;
        beat           <= '0;
        bcnt           <= '0;
        lfsr           <= SEED_EFF;
        err_cnt        <= '0;
        first_err_addr <= '0;
        pass           <= 1'b0;
        busy           <= 1'b1;
      end

      if (state == S_DONE) begin
        done <= 1'b1;
        pass <= (err_cnt == 16'd0);
      end

      if (ack) begin
        if (!wb_we_o && (wb_dat_i != lfsr)) begin
          if (err_cnt == 16'd0) first_err_addr <= addr;
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
        addr <= addr + AW'(1);
        lfsr <= lfsr_step(lfsr);
        if (last_beat) begin
          beat <= '0;
          if (last_burst) begin
            bcnt <= '0;
            // Read phase regenerates the same pattern
            // over the same region.
            if (state == S_WR) begin
              lfsr <= SEED_EFF;
              addr <= base;
            end
          end else begin
            bcnt <= bcnt + 16'd1;
          end
        end else begin
          beat <= beat + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdr_wb_bist.sv
// Bench for sdr_wb_bist: registered-ack memory slave plus
// a beat scoreboard fed from an independent pattern model.
module tb_sdr_wb_bist;

  localparam int          AW   = 26;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [15:0]   cfg_nb = '0;
  logic [7:0]    cfg_len = '0;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [AW-1:0] adr;
  logic [31:0]   dat_o;
  logic [31:0]   rdat;
  logic          ack;
  logic          busy, done, pass;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err;

  sdr_wb_bist #(.AW(AW), .DW(32), .SEED(SEED)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .sdr_init_done (init_done),
    .start         (start),
    .cfg_start_addr(cfg_addr),
    .cfg_num_bursts(cfg_nb),
    .cfg_burst_len (cfg_len),
    .wb_cyc_o      (cyc),
    .wb_stb_o      (stb),
    .wb_we_o       (we),
    .wb_sel_o      (sel),
    .wb_addr_o     (adr),
    .wb_dat_o      (dat_o),
    .wb_dat_i      (rdat),
    .wb_ack_i      (ack),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_err_addr(first_err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Slave: ack after ws cycles of strobe, registered.
  int            ws = 1;
  int            wcnt = 0;
  logic          flip_en = 1'b0;
  logic [AW-1:0] flip_addr = '0;
  logic [31:0]   mem [logic [AW-1:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack  <= 1'b0;
      wcnt <= 0;
      rdat <= '0;
    end else begin
      ack <= 1'b0;
      if (cyc && stb && !ack) begin
        if (wcnt >= ws - 1) begin
          ack  <= 1'b1;
          wcnt <= 0;
          if (we) mem[adr] = dat_o;
          else rdat <= (mem.exists(adr) ? mem[adr] : 32'h0) ^
                       ((flip_en && adr == flip_addr) ?
                        32'h1 : 32'h0);
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [31:0]   d;
  } beat_t;

  beat_t exp_q[$];
  int    gap_q[$];
  int    cyc_seen = 0;
  int    low_run = 0;
  bit    seen_hi = 0;
  beat_t e;

  always @(negedge clk) begin
    if (cyc) begin
      cyc_seen++;
      if (seen_hi && low_run > 0) gap_q.push_back(low_run);
      low_run = 0;
      seen_hi = 1;
    end else if (seen_hi) begin
      low_run++;
    end
    if (cyc && stb && ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("beat_we", we, e.we);
        chk("beat_addr", adr, e.a);
        chk("beat_sel", sel, 4'hF);
        if (e.we) chk("beat_wdata", dat_o, e.d);
      end
    end
  end

  int            exp_err;
  logic [AW-1:0] exp_first;

  task automatic begin_test(input logic [AW-1:0] a,
                            input int nb, input int len,
                            input int w, input logic fe,
                            input logic [AW-1:0] fa);
    int            n;
    logic [31:0]   l;
    logic [AW-1:0] ad;
    beat_t         b;
    exp_q.delete();
    gap_q.delete();
    seen_hi = 0;
    low_run = 0;
    cyc_seen = 0;
    ws = w;
    flip_en = fe;
    flip_addr = fa;
    n = (len == 0) ? 1 : len;
    exp_err = 0;
    exp_first = '0;
    l = SEED;
    for (int i = 0; i < nb * n; i++) begin
      ad = a + AW'(i);
      b.we = 1'b1; b.a = ad; b.d = l;
      exp_q.push_back(b);
      l = lstep(l);
    end
    for (int i = 0; i < nb * n; i++) begin
      ad = a + AW'(i);
      b.we = 1'b0; b.a = ad; b.d = '0;
      exp_q.push_back(b);
      if (fe && ad == fa) begin
        if (exp_err == 0) exp_first = ad;
        exp_err++;
      end
    end
    cfg_addr = a;
    cfg_nb = 16'(nb);
    cfg_len = 8'(len);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_test(input string tag);
    bit got = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk({tag, "_done_seen"}, got, 1);
    if (got) begin
      chk({tag, "_pass"}, pass, (exp_err == 0));
      chk({tag, "_err_cnt"}, err_cnt, exp_err);
      chk({tag, "_first_err"}, first_err, exp_first);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_start_at_done_ignored"}, busy, 0);
      chk({tag, "_q_empty"}, exp_q.size(), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_bus", {cyc, stb, we, sel}, 0);
    chk("reset_addr_dat", {adr, dat_o}, 0);
    chk("reset_status", {busy, done, pass}, 0);
    chk("reset_err", {err_cnt, first_err}, 0);
    rst = 1'b0;
    init_done = 1'b1;
    @(negedge clk);

    begin_test(26'h10000, 1, 4, 1, 1'b0, '0);
    finish_test("basic");

    begin_test(26'h400, 3, 8, 2, 1'b0, '0);
    repeat (20) @(negedge clk);
    cfg_addr = 26'h777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_test("multi");
    chk("multi_gap_count", gap_q.size(), 5);
    foreach (gap_q[i]) chk("multi_gap_len", gap_q[i], 1);

    begin_test(26'h200, 1, 16, 1, 1'b1, 26'h205);
    finish_test("flip");

    begin_test(26'h3000, 2, 0, 1, 1'b0, '0);
    finish_test("len0");
    chk("len0_gap_count", gap_q.size(), 3);

    begin_test(26'h50, 0, 4, 1, 1'b0, '0);
    chk("nb0_done_early", done, 0);
    @(negedge clk);
    chk("nb0_done", done, 1);
    chk("nb0_pass", pass, 1);
    chk("nb0_no_cyc", cyc_seen, 0);
    repeat (2) @(negedge clk);

    init_done = 1'b0;
    begin_test(26'h80, 1, 4, 1, 1'b0, '0);
    repeat (10) @(negedge clk);
    chk("init_gate_no_cyc", cyc_seen, 0);
    init_done = 1'b1;
    finish_test("init");

    begin_test(26'h900, 2, 16, 1, 1'b0, '0);
    for (int i = 0; i < 200 && cyc_seen < 6; i++)
      @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_burst", {cyc, stb, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);

    begin_test(26'h900, 1, 8, 1, 1'b0, '0);
    finish_test("after_rst");

    begin_test(26'h3FFFFFE, 1, 4, 1, 1'b0, '0);
    finish_test("wrap");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdr_wb_bist.md
Name: sdr_wb_bist

Overview:
- Synthesizable Wishbone master traffic generator and checker that drives the SDRAM controller's application-side Wishbone slave port.
- Writes an LFSR data pattern as a sequence of bursts over a contiguous word-address region, then reads the region back and compares it against the regenerated pattern.
- Reports error count, first failing address and pass/fail status.
- Replaces task-driven bench stimulus for on-silicon and long-run checks.

Parameters:
- AW, 26, Wishbone word-address width (wb_addr_o width).
- DW, 32, data width. Fixed at 32; the LFSR is 32 bits.
- SEED, 32'hACE1_2468, LFSR seed loaded at start of each phase. A value of 0 is replaced by 32'h1.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- sdr_init_done  in  1  controller init complete; no bus cycle is issued before it is high.
- start  in  1  one-cycle pulse; begins a test. Ignored while busy=1.
- cfg_start_addr  in  AW  first word address; sampled on accepted start.
- cfg_num_bursts  in  16  number of bursts; sampled on accepted start.
- cfg_burst_len  in  8  beats per burst; sampled on accepted start; 0 is treated as 1.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  1 = write.
- wb_sel_o  out  4  byte selects; always 4'hF when stb=1, else 0.
- wb_addr_o  out  AW  word address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  slave acknowledge.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at test completion.
- pass  out  1  valid from done until the next accepted start; 1 when err_cnt==0.
- err_cnt  out  16  mismatch count, saturating at 16'hFFFF.
- first_err_addr  out  AW  address of the first mismatch; 0 if none.

Behaviour:
- Reset: all outputs 0; state IDLE; LFSR = SEED (0 replaced by 1).
- The async reset mid-transfer drops cyc/stb immediately. No bus cleanup is performed.
- LFSR step: next = {l[30:0], l[31]^l[21]^l[1]^l[0]}.
- The current value l is the beat data; the LFSR steps on every acked beat.
- States:
  - IDLE: start=1 -> latch cfg, clear err_cnt, first_err_addr and pass; load LFSR=SEED; addr=cfg_start_addr; busy=1.
    - If cfg_num_bursts==0 -> DONE.
    - Else -> WAIT_INIT.
  - WAIT_INIT: sdr_init_done=1 -> WR. If already high, the transition happens on the next cycle.
  - WR: cyc=stb=we=1, dat_o=l, addr_o=addr. Signals are held stable until wb_ack_i.
    - On ack: addr+=1 (mod 2^AW); LFSR steps; beat+=1.
    - Last beat of burst -> WR_GAP. Last beat of last burst -> RD_GAP, with LFSR reloaded to SEED and addr reloaded to cfg_start_addr.
  - WR_GAP: cyc=stb=0 for exactly one cycle -> WR.
  - RD_GAP: cyc=stb=0 for exactly one cycle -> RD.
  - RD: cyc=stb=1, we=0.
    - On ack: compare wb_dat_i to l. On mismatch, err_cnt+=1 (saturating); first_err_addr=addr_o if err_cnt was 0.
    - Then addr, LFSR and beat advance as in WR.
    - Last beat of burst -> RD_GAP. Last beat of last burst -> DONE.
  - DONE: one cycle; done=1; pass=(err_cnt==0); busy=0 -> IDLE.
- Burst boundaries:
  - Each burst is one cyc assertion of burst_len beats.
  - cyc is deasserted for 1 cycle between bursts and between the write and read phases.
- Throughput: with zero-wait ack (ack in the same cycle as stb), one beat per clock within a burst. The bench uses the slave's registered ack, giving ≥1 wait state.
- ack while stb=0 is ignored.
- The total word count is num_bursts*burst_len, up to 16.7M. An address overflow wraps modulo 2^AW silently.
- start on the same cycle as done is ignored, because busy is still 1 in DONE.
- Combinational paths: none from wb_ack_i or wb_dat_i to outputs. All outputs are registered except the bus signals, which are decoded from state registers.

Test Plan:
- Reset, then start with addr=0x10000, bursts=1, len=4, and a model returning the written data:
  - 4 writes to 0x10000..0x10003 with data 0xACE12468 then its LFSR successors.
  - 4 reads follow.
  - done pulse; pass=1; err_cnt=0.
- bursts=3, len=8 with a 2-wait-state slave:
  - cyc drops for exactly 1 cycle after beats 8 and 16 and between phases.
  - 24 writes and 24 reads, pass=1.
- Model flips bit 0 of read data at address start+5, with addr=0x200 and len=16:
  - err_cnt=1; first_err_addr=0x205; pass=0.
- cfg_burst_len=0, bursts=2:
  - Behaves as len=1: 2 single-beat writes then 2 single-beat reads.
- cfg_num_bursts=0:
  - No cyc assertion.
  - done pulses 2 cycles after start; pass=1.
- Test cases covering start gating, reset and wrap:
  - Start with sdr_init_done=0: no cyc until init_done rises.
  - Assert wb_rst_i mid-write-burst: cyc/stb/busy are 0 within the same cycle.
  - A new start after reset runs to completion.
  - Run addr=2^AW-2, len=4: addresses 3FFFFFE, 3FFFFFF, 0, 1.
